// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 pipeline: controller states, PC sources,
// mcause codes and the write-back selectors used by the stage registers.
package msrv32_pkg;

    localparam logic [1:0] ST_RESET       = 2'd0;
    localparam logic [1:0] ST_OPERATING   = 2'd1;
    localparam logic [1:0] ST_TRAP_TAKEN  = 2'd2;
    localparam logic [1:0] ST_TRAP_RETURN = 2'd3;

    localparam logic [1:0] PC_BOOT = 2'b00;
    localparam logic [1:0] PC_SEQ  = 2'b01;
    localparam logic [1:0] PC_TRAP = 2'b10;
    localparam logic [1:0] PC_EPC  = 2'b11;

    // Exception codes (i_or_e = 0)
    localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR  = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_ACCESS    = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_STORE_ACCESS   = 4'd7;
    localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;
    // Interrupt codes (i_or_e = 1)
    localparam logic [3:0] CAUSE_MSI            = 4'd3;
    localparam logic [3:0] CAUSE_MTI            = 4'd7;
    localparam logic [3:0] CAUSE_MEI            = 4'd11;

    localparam logic [2:0] WB_ALU  = 3'd0;
    localparam logic [2:0] WB_LOAD = 3'd1;
    localparam logic [2:0] WB_CSR  = 3'd2;
    localparam logic [2:0] WB_PC4  = 3'd3;
    localparam logic [2:0] WB_IMM  = 3'd4;

endpackage

// File: rtl/msrv32_trap_prio.sv
// Combinational trap priority encoder: picks the highest-priority pending
// exception or enabled interrupt and reports its mcause code.
module msrv32_trap_prio
    import msrv32_pkg::*;
(
    input  logic       misaligned_instr_i,
    input  logic       illegal_instr_i,
    input  logic       ebreak_i,
    input  logic       ecall_i,
    input  logic       misaligned_load_i,
    input  logic       misaligned_store_i,
    input  logic       timeout_i,
    input  logic       store_i,
    input  logic       mie_i,
    input  logic       meie_i,
    input  logic       mtie_i,
    input  logic       msie_i,
    input  logic       meip_i,
    input  logic       mtip_i,
    input  logic       msip_i,
    output logic       trap_req_o,
    output logic [3:0] cause_o,
    output logic       is_irq_o
);

    // Fixed-priority selection, synchronous exceptions ahead of interrupts
    always_comb begin
        trap_req_o = 1'b1;
        cause_o    = CAUSE_INSTR_MISALIGN;
        is_irq_o   = 1'b0;
        if (misaligned_instr_i) begin
            cause_o = CAUSE_INSTR_MISALIGN;
        end else if (illegal_instr_i) begin
            cause_o = CAUSE_ILLEGAL_INSTR;
        end else if (ebreak_i) begin
            cause_o = CAUSE_BREAKPOINT;
        end else if (ecall_i) begin
            cause_o = CAUSE_ECALL_M;
        end else if (misaligned_load_i) begin
            cause_o = CAUSE_LOAD_MISALIGN;
        end else if (misaligned_store_i) begin
            cause_o = CAUSE_STORE_MISALIGN;
        end else if (timeout_i) begin
            cause_o = store_i ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
        end else if (mie_i && meie_i && meip_i) begin
            cause_o  = CAUSE_MEI;
            is_irq_o = 1'b1;
        end else if (mie_i && msie_i && msip_i) begin
            cause_o  = CAUSE_MSI;
            is_irq_o = 1'b1;
        end else if (mie_i && mtie_i && mtip_i) begin
            cause_o  = CAUSE_MTI;
            is_irq_o = 1'b1;
        end else begin
            trap_req_o = 1'b0;
        end
    end

endmodule

// File: rtl/msrv32_pipe_ctrl.sv
// Stage-2/3 pipeline sequencing: load/stall/flush decisions, next-PC source,
// trap entry / mret FSM and the data-memory wait timeout.
module msrv32_pipe_ctrl
    import msrv32_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 8
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       ecall_in,
    input  logic       ebreak_in,
    input  logic       mret_in,
    input  logic       branch_taken_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    input  logic       dmem_req_in,
    input  logic       dmem_wr_in,
    input  logic       dmem_ready_in,
    output logic       stall_out,
    output logic       flush_out,
    output logic [1:0] pc_src_out,
    output logic       trap_taken_out,
    output logic       set_epc_out,
    output logic       set_cause_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic [3:0] cause_out,
    output logic       i_or_e_out
);

    localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(MEM_TIMEOUT);

    logic [1:0]      state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [3:0]      cause_q, cause_d;
    logic            irq_q, irq_d;

    logic            operating_s;
    logic            waiting_s;
    logic            timeout_s;
    logic            stall_s;
    logic            trap_req_s;
    logic [3:0]      trap_cause_s;
    logic            trap_irq_s;
    logic            trap_take_s;
    logic            mret_take_s;

    assign operating_s = (state_q == ST_OPERATING);
    assign waiting_s   = dmem_req_in & ~dmem_ready_in;
    assign timeout_s   = waiting_s & (cnt_q == TIMEOUT_C);
    assign stall_s     = operating_s & waiting_s & (cnt_q < TIMEOUT_C);
    // A stalled instruction has not advanced, so nothing may retire or trap yet
    assign trap_take_s = operating_s & ~stall_s & trap_req_s;
    assign mret_take_s = operating_s & ~stall_s & mret_in & ~trap_req_s;

    msrv32_trap_prio u_trap_prio (
        .misaligned_instr_i (misaligned_instr_in),
        .illegal_instr_i    (illegal_instr_in),
        .ebreak_i           (ebreak_in),
        .ecall_i            (ecall_in),
        .misaligned_load_i  (misaligned_load_in),
        .misaligned_store_i (misaligned_store_in),
        .timeout_i          (timeout_s),
        .store_i            (dmem_wr_in),
        .mie_i              (mie_in),
        .meie_i             (meie_in),
        .mtie_i             (mtie_in),
        .msie_i             (msie_in),
        .meip_i             (meip_in),
        .mtip_i             (mtip_in),
        .msip_i             (msip_in),
        .trap_req_o         (trap_req_s),
        .cause_o            (trap_cause_s),
        .is_irq_o           (trap_irq_s)
    );

    // Next-state, wait-counter and trap-cause update logic
    always_comb begin
        state_d = ST_RESET;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        irq_d   = irq_q;
        case (state_q)
            ST_RESET:       state_d = ST_OPERATING;
            ST_OPERATING: begin
                if (trap_take_s) begin
                    state_d = ST_TRAP_TAKEN;
                end else if (mret_take_s) begin
                    state_d = ST_TRAP_RETURN;
                end else begin
                    state_d = ST_OPERATING;
                end
            end
            ST_TRAP_TAKEN:  state_d = ST_OPERATING;
            ST_TRAP_RETURN: state_d = ST_OPERATING;
            default:        state_d = ST_RESET;
        endcase

        // Counter only measures waits seen by an operating pipeline
        if (!operating_s || trap_take_s || !waiting_s) begin
            cnt_d = '0;
        end else if (cnt_q != TIMEOUT_C) begin
            cnt_d = cnt_q + TO_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (trap_take_s) begin
            cause_d = trap_cause_s;
            irq_d   = trap_irq_s;
        end else begin
            cause_d = cause_q;
            irq_d   = irq_q;
        end
    end

    // State, counter and cause registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            cause_q <= 4'd0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            irq_q   <= irq_d;
        end
    end

    // Per-state output decode
    always_comb begin
        pc_src_out     = PC_BOOT;
        flush_out      = 1'b0;
        stall_out      = 1'b0;
        trap_taken_out = 1'b0;
        set_epc_out    = 1'b0;
        set_cause_out  = 1'b0;
        mie_clear_out  = 1'b0;
        mie_set_out    = 1'b0;
        case (state_q)
            ST_RESET: begin
                pc_src_out = PC_BOOT;
                flush_out  = 1'b1;
            end
            ST_OPERATING: begin
                pc_src_out = PC_SEQ;
                stall_out  = stall_s;
                flush_out  = branch_taken_in & ~stall_s & ~trap_take_s & ~mret_take_s;
            end
            ST_TRAP_TAKEN: begin
                pc_src_out     = PC_TRAP;
                flush_out      = 1'b1;
                trap_taken_out = 1'b1;
                set_epc_out    = 1'b1;
                set_cause_out  = 1'b1;
                mie_clear_out  = 1'b1;
            end
            ST_TRAP_RETURN: begin
                pc_src_out  = PC_EPC;
                flush_out   = 1'b1;
                mie_set_out = 1'b1;
            end
            default: begin
                pc_src_out = PC_BOOT;
                flush_out  = 1'b1;
            end
        endcase
    end

    assign cause_out  = cause_q;
    assign i_or_e_out = irq_q;

endmodule

// File: tb/tb_msrv32_pipe_ctrl.sv
// Directed self-checking bench for msrv32_pipe_ctrl (MEM_TIMEOUT = 16).
module tb_msrv32_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset_in;
    logic       illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in;
    logic       ecall_in, ebreak_in, mret_in, branch_taken_in;
    logic       mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;
    logic       dmem_req_in, dmem_wr_in, dmem_ready_in;
    logic       stall_out, flush_out, trap_taken_out, set_epc_out, set_cause_out;
    logic       mie_clear_out, mie_set_out, i_or_e_out;
    logic [1:0] pc_src_out;
    logic [3:0] cause_out;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // {pc_src, flush, stall, trap_taken, set_epc, set_cause, mie_clear, mie_set}
    logic [8:0] ctl;
    logic [4:0] ctx;
    assign ctl = {pc_src_out, flush_out, stall_out, trap_taken_out, set_epc_out,
                  set_cause_out, mie_clear_out, mie_set_out};
    assign ctx = {i_or_e_out, cause_out};

    localparam logic [8:0] C_RESET = 9'b00_1_0_00000;
    localparam logic [8:0] C_OP    = 9'b01_0_0_00000;
    localparam logic [8:0] C_FLUSH = 9'b01_1_0_00000;
    localparam logic [8:0] C_STALL = 9'b01_0_1_00000;
    localparam logic [8:0] C_TRAP  = 9'b10_1_0_11110;
    localparam logic [8:0] C_RET   = 9'b11_1_0_00001;

    msrv32_pipe_ctrl #(.MEM_TIMEOUT(16), .TO_W(8)) dut (
        .clk_in              (clk),
        .reset_in            (reset_in),
        .illegal_instr_in    (illegal_instr_in),
        .misaligned_instr_in (misaligned_instr_in),
        .misaligned_load_in  (misaligned_load_in),
        .misaligned_store_in (misaligned_store_in),
        .ecall_in            (ecall_in),
        .ebreak_in           (ebreak_in),
        .mret_in             (mret_in),
        .branch_taken_in     (branch_taken_in),
        .mie_in              (mie_in),
        .meie_in             (meie_in),
        .mtie_in             (mtie_in),
        .msie_in             (msie_in),
        .meip_in             (meip_in),
        .mtip_in             (mtip_in),
        .msip_in             (msip_in),
        .dmem_req_in         (dmem_req_in),
        .dmem_wr_in          (dmem_wr_in),
        .dmem_ready_in       (dmem_ready_in),
        .stall_out           (stall_out),
        .flush_out           (flush_out),
        .pc_src_out          (pc_src_out),
        .trap_taken_out      (trap_taken_out),
        .set_epc_out         (set_epc_out),
        .set_cause_out       (set_cause_out),
        .mie_clear_out       (mie_clear_out),
        .mie_set_out         (mie_set_out),
        .cause_out           (cause_out),
        .i_or_e_out          (i_or_e_out)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        illegal_instr_in = 1'b0; misaligned_instr_in = 1'b0;
        misaligned_load_in = 1'b0; misaligned_store_in = 1'b0;
        ecall_in = 1'b0; ebreak_in = 1'b0; mret_in = 1'b0; branch_taken_in = 1'b0;
        mie_in = 1'b0; meie_in = 1'b0; mtie_in = 1'b0; msie_in = 1'b0;
        meip_in = 1'b0; mtip_in = 1'b0; msip_in = 1'b0;
        dmem_req_in = 1'b0; dmem_wr_in = 1'b0; dmem_ready_in = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_in = 1'b1;
        repeat (3) @(posedge clk);
        #1; reset_in = 1'b0; #2;
        cmp_cnt++;
        if (ctl !== C_RESET) begin $display("FAIL reset_boot: got %b want %b", ctl, C_RESET); err_cnt++; end
        next_cycle(); #2;
        cmp_cnt++;
        if (ctl !== C_OP) begin $display("FAIL reset_op: got %b want %b", ctl, C_OP); err_cnt++; end
        cmp_cnt++;
        if (ctx !== 5'd0) begin $display("FAIL reset_cause: got %b want %b", ctx, 5'd0); err_cnt++; end
    endtask

    task automatic test_exception();
        next_cycle();
        illegal_instr_in = 1'b1; ecall_in = 1'b1; #2;
        cmp_cnt++;
        if (ctl !== C_OP) begin $display("FAIL exc_pre: got %b want %b", ctl, C_OP); err_cnt++; end
        next_cycle(); clear_inputs(); #2;
        cmp_cnt++;
        if (ctl !== C_TRAP) begin $display("FAIL exc_trap: got %b want %b", ctl, C_TRAP); err_cnt++; end
        cmp_cnt++;
        if (ctx !== {1'b0, 4'd2}) begin $display("FAIL exc_cause: got %b want %b", ctx, {1'b0, 4'd2}); err_cnt++; end
        next_cycle(); #2;
        cmp_cnt++;
        if (ctl !== C_OP) begin $display("FAIL exc_after: got %b want %b", ctl, C_OP); err_cnt++; end
    endtask

    task automatic test_interrupt();
        next_cycle();
        mie_in = 1'b1; meie_in = 1'b1; meip_in = 1'b1; mtie_in = 1'b1; mtip_in = 1'b1; #2;
        next_cycle(); clear_inputs(); #2;
        cmp_cnt++;
        if (ctl !== C_TRAP) begin $display("FAIL irq_ext_trap: got %b want %b", ctl, C_TRAP); err_cnt++; end
        cmp_cnt++;
        if (ctx !== {1'b1, 4'd11}) begin $display("FAIL irq_ext_cause: got %b want %b", ctx, {1'b1, 4'd11}); err_cnt++; end
        next_cycle();
        // Software interrupt outranks timer
        mie_in = 1'b1; msie_in = 1'b1; msip_in = 1'b1; mtie_in = 1'b1; mtip_in = 1'b1; #2;
        next_cycle(); clear_inputs(); #2;
        cmp_cnt++;
        if (ctx !== {1'b1, 4'd3}) begin $display("FAIL irq_sw_cause: got %b want %b", ctx, {1'b1, 4'd3}); err_cnt++; end
        next_cycle();
        mie_in = 1'b1; mtie_in = 1'b1; mtip_in = 1'b1; #2;
        next_cycle(); clear_inputs(); #2;
        cmp_cnt++;
        if (ctx !== {1'b1, 4'd7}) begin $display("FAIL irq_tmr_cause: got %b want %b", ctx, {1'b1, 4'd7}); err_cnt++; end
        next_cycle();
        mie_in = 1'b0; meie_in = 1'b1; meip_in = 1'b1; mtie_in = 1'b1; mtip_in = 1'b1; #2;
        next_cycle(); #2;
        cmp_cnt++;
        if (ctl !== C_OP) begin $display("FAIL irq_masked: got %b want %b", ctl, C_OP); err_cnt++; end
        cmp_cnt++;
        if (ctx !== {1'b1, 4'd7}) begin $display("FAIL irq_masked_hold: got %b want %b", ctx, {1'b1, 4'd7}); err_cnt++; end
        clear_inputs();
    endtask

    task automatic test_timeout(input logic is_store, input logic [3:0] exp_cause);
        int n;
        n = 0;
        next_cycle();
        dmem_req_in = 1'b1; dmem_wr_in = is_store; dmem_ready_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (stall_out !== 1'b1) break;
            n++;
            next_cycle();
        end
        cmp_cnt++;
        if (n !== 16) begin $display("FAIL to_stall_len: got %0d want %0d", n, 16); err_cnt++; end
        cmp_cnt++;
        if (ctl !== C_OP) begin $display("FAIL to_release: got %b want %b", ctl, C_OP); err_cnt++; end
        next_cycle(); clear_inputs(); #2;
        cmp_cnt++;
        if (ctl !== C_TRAP) begin $display("FAIL to_trap: got %b want %b", ctl, C_TRAP); err_cnt++; end
        cmp_cnt++;
        if (ctx !== {1'b0, exp_cause}) begin $display("FAIL to_cause: got %b want %b", ctx, {1'b0, exp_cause}); err_cnt++; end
        next_cycle(); #2;
        cmp_cnt++;
        if (ctl !== C_OP) begin $display("FAIL to_after: got %b want %b", ctl, C_OP); err_cnt++; end
    endtask

    task automatic test_ready_in_time();
        next_cycle();
        dmem_req_in = 1'b1; dmem_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            cmp_cnt++;
            if (ctl !== C_STALL) begin $display("FAIL rdy_stall%0d: got %b want %b", i, ctl, C_STALL); err_cnt++; end
            next_cycle();
        end
        dmem_ready_in = 1'b1; #2;
        cmp_cnt++;
        if (ctl !== C_OP) begin $display("FAIL rdy_done: got %b want %b", ctl, C_OP); err_cnt++; end
        next_cycle(); clear_inputs(); #2;
        cmp_cnt++;
        if (ctl !== C_OP) begin $display("FAIL rdy_no_trap: got %b want %b", ctl, C_OP); err_cnt++; end
    endtask

    task automatic test_branch();
        next_cycle();
        branch_taken_in = 1'b1; #2;
        cmp_cnt++;
        if (ctl !== C_FLUSH) begin $display("FAIL br_flush: got %b want %b", ctl, C_FLUSH); err_cnt++; end
        next_cycle();
        dmem_req_in = 1'b1; #2;
        cmp_cnt++;
        if (ctl !== C_STALL) begin $display("FAIL br_stall_noflush: got %b want %b", ctl, C_STALL); err_cnt++; end
        clear_inputs();
    endtask

    task automatic test_mret();
        next_cycle();
        mret_in = 1'b1; branch_taken_in = 1'b1; #2;
        cmp_cnt++;
        if (ctl !== C_OP) begin $display("FAIL mret_pre: got %b want %b", ctl, C_OP); err_cnt++; end
        next_cycle(); clear_inputs(); #2;
        cmp_cnt++;
        if (ctl !== C_RET) begin $display("FAIL mret_ret: got %b want %b", ctl, C_RET); err_cnt++; end
        next_cycle(); #2;
        cmp_cnt++;
        if (ctl !== C_OP) begin $display("FAIL mret_after: got %b want %b", ctl, C_OP); err_cnt++; end
        next_cycle();
        mret_in = 1'b1; ecall_in = 1'b1; #2;
        next_cycle(); clear_inputs(); #2;
        cmp_cnt++;
        if (ctl !== C_TRAP) begin $display("FAIL mret_ecall_trap: got %b want %b", ctl, C_TRAP); err_cnt++; end
        cmp_cnt++;
        if (ctx !== {1'b0, 4'd11}) begin $display("FAIL mret_ecall_cause: got %b want %b", ctx, {1'b0, 4'd11}); err_cnt++; end
        next_cycle(); #2;
    endtask

    task automatic test_reset_midwait();
        next_cycle();
        dmem_req_in = 1'b1; dmem_ready_in = 1'b0;
        repeat (10) begin #2; next_cycle(); end
        reset_in = 1'b1; #2;
        cmp_cnt++;
        if (ctl !== C_STALL) begin $display("FAIL mw_stall10: got %b want %b", ctl, C_STALL); err_cnt++; end
        next_cycle();
        reset_in = 1'b0; #2;
        cmp_cnt++;
        if (ctl !== C_RESET) begin $display("FAIL mw_reset: got %b want %b", ctl, C_RESET); err_cnt++; end
        cmp_cnt++;
        if (ctx !== 5'd0) begin $display("FAIL mw_cause_clr: got %b want %b", ctx, 5'd0); err_cnt++; end
        dmem_req_in = 1'b0;
        next_cycle(); #2;
        cmp_cnt++;
        if (ctl !== C_OP) begin $display("FAIL mw_op: got %b want %b", ctl, C_OP); err_cnt++; end
        test_timeout(1'b0, 4'd5);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_exception();
        test_interrupt();
        test_timeout(1'b0, 4'd5);
        test_timeout(1'b1, 4'd7);
        test_ready_in_time();
        test_branch();
        test_mret();
        test_reset_midwait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
